controle_displays: RTL and testbench
====================================

# controle_displays

Sequential controller that owns the four-digit decimal display path of the processor. It accepts output values from the core over a valid/ready handshake and converts them to BCD with an iterative shift-add-3 engine, one bit per clock. It holds the committed digits stable between updates and time-multiplexes them onto a shared four-digit seven-segment bus. It replaces the purely combinational conversion at the display output, so that conversion logic is never on the core's critical path.

## Interface

- REFRESH_DIV, 50000: clock cycles each digit stays selected during scanning; legal range is ≥ 1.
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- numero  in  32  value written by the core; only bits [15:0] are used.
- escrever  in  1  write strobe (valid); accepted only in a cycle where pronto=1.
- pronto  out  1  ready; 1 when idle and able to accept a write.
- milhar, centena, dezena, unidade  out  4 each  committed BCD digits, registered.
- negativo  out  1  committed value was negative (see Configuration).
- estouro  out  1  committed magnitude exceeds 9999.
- anodo  out  4  one-hot, active-low digit select; bit 0 selects unidade and bit 3 selects milhar.
- digito_atual  out  4  BCD digit that belongs to the currently selected anodo.

## Operation

- The FSM has three states: OCIOSO, CONVERTE and ATUALIZA.
- OCIOSO: pronto=1. On escrever=1 the block:
  - latches the magnitude of numero[15:0] into a 16-bit shift register;
  - latches the sign;
  - clears a 20-bit BCD accumulator (five digits);
  - clears the bit counter;
  - moves to CONVERTE.
- CONVERTE: pronto=0. Each cycle:
  - every BCD digit ≥ 5 is incremented by 3;
  - the accumulator shifts left one place and takes the MSB of the shift register as its new LSB;
  - the shift register shifts left;
  - the counter increments.
  - After the 16th shift the FSM moves to ATUALIZA.
- ATUALIZA: commits the result in one cycle, then returns to OCIOSO.
  - If the fifth digit (bits [19:16]) is nonzero: estouro=1 and all four digit outputs are 4'hF, the error/blank code.
  - Otherwise: estouro=0 and the low four digits go to unidade..milhar.
  - negativo is committed from the latched sign.
- escrever while pronto=0 is ignored. It is not queued and does not disturb the conversion in progress.
- Committed outputs change only in ATUALIZA.
- Scanning runs independently of the FSM:
  - a divider counts 0..REFRESH_DIV-1;
  - on wrap, anodo rotates in the order unidade→dezena→centena→milhar→unidade;
  - digito_atual is a combinational select of the committed digit for the current anodo.

## Timing

- Reset values:
  - pronto=1, state OCIOSO;
  - all four digits 0, negativo=0, estouro=0;
  - anodo=4'b1110, digito_atual=0, divider=0.
- Latency: a write accepted at edge N puts the new digits on the outputs after edge N+17.
  - Edge N+1 through N+16 are the 16 shift cycles.
  - Edge N+17 is ATUALIZA.
  - pronto=0 from after edge N until after edge N+17, then 1 again.
- Back-to-back writes: the next write can be accepted at edge N+18, giving a throughput of one write per 18 cycles.
- Reset asserted mid-conversion: the conversion is abandoned, and all outputs and state return to reset values immediately, without waiting for a clock edge.
- REFRESH_DIV=1: anodo rotates every cycle.

## Configuration

- DISPLAY_SINAL_EN defined:
  - numero[15:0] is two's complement;
  - a negative input is converted as its magnitude, and negativo is committed as 1;
  - -32768 has magnitude 32768, so it commits estouro=1 and negativo=1.
- DISPLAY_SINAL_EN undefined:
  - numero[15:0] is unsigned, range 0..65535;
  - the negativo output stays 0 at all times.

## Structure

- Package controle_displays_pkg holds:
  - the state enum (OCIOSO, CONVERTE, ATUALIZA);
  - BCD_W=4 and NUM_BITS=16;
  - DIG_ERRO=4'hF.
- Sub-module varredura_displays contains the divider, the anodo rotation and the digito_atual mux. It is parameterised by REFRESH_DIV.
- The conversion FSM and datapath live in the top module.

## Test plan

- Write 1234 from idle, then hold escrever=0. pronto must be low for exactly 17 cycles. After that, milhar/centena/dezena/unidade = 1/2/3/4 with estouro=0 and negativo=0.
- Overflow boundary: write 9999, which must commit 9/9/9/9 with estouro=0. Then write 10000, which must commit F/F/F/F with estouro=1.
- With DISPLAY_SINAL_EN:
  - writing 16'hFFFF commits 0/0/0/1 with negativo=1;
  - writing 16'h8000 commits estouro=1 and negativo=1.
- Without DISPLAY_SINAL_EN: writing 16'hFFFF (65535) commits estouro=1 and negativo=0.
- Write 42, then pulse escrever with 7777 five cycles later. 7777 must be ignored: only 0/0/4/2 is committed, and pronto returns after the standard 17 cycles.
- Assert reset 8 cycles into converting 5555. All outputs must return to reset values at once. After reset is released, a write of 0 commits 0/0/0/0 with estouro=0.
- Scanning with REFRESH_DIV=4 and 1/2/3/4 committed:
  - anodo steps 1110→1101→1011→0111→1110, one step every 4 cycles;
  - digito_atual reads 4,3,2,1 in lock-step with anodo.

Source files
------------

// File: rtl/controle_displays_pkg.sv
// Shared types and constants for the four-digit decimal display controller.
package controle_displays_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  localparam int BCD_W    = 4;
  localparam int NUM_BITS = 16;
  localparam int NUM_DIG  = 5;
  localparam int ACC_W    = NUM_DIG * BCD_W;
  localparam int CNT_W    = $clog2(NUM_BITS);

  localparam logic [BCD_W-1:0] DIG_ERRO = 4'hF;

  // Shift-add-3 correction applied to every BCD digit before each shift.
  function automatic logic [ACC_W-1:0] soma3(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    r = acc;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (r[i*BCD_W +: BCD_W] >= 4'd5)
        r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/controle_displays_varredura.sv
// Digit scanning: refresh divider, active-low anode rotation and digit mux.
module varredura_displays
  import controle_displays_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [BCD_W-1:0] milhar_i,
  input  logic [BCD_W-1:0] centena_i,
  input  logic [BCD_W-1:0] dezena_i,
  input  logic [BCD_W-1:0] unidade_i,
  output logic [3:0]       anodo_o,
  output logic [BCD_W-1:0] digito_o
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic [3:0]       anodo_q;
  logic             virada;

  assign virada = (div_q == DIV_W'(REFRESH_DIV - 1));

  // Rotation order unidade -> dezena -> centena -> milhar (left rotate).
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      div_q   <= '0;
      anodo_q <= 4'b1110;
    end else if (virada) begin
      div_q   <= '0;
      anodo_q <= {anodo_q[2:0], anodo_q[3]};
    end else begin
      div_q   <= div_q + 1'b1;
    end
  end

  always_comb begin
    digito_o = '0;
    case (anodo_q)
      4'b1110: digito_o = unidade_i;
      4'b1101: digito_o = dezena_i;
      4'b1011: digito_o = centena_i;
      4'b0111: digito_o = milhar_i;
      default: digito_o = '0;
    endcase
  end

  assign anodo_o = anodo_q;

endmodule

// File: rtl/controle_displays.sv
// Display controller: handshake write, iterative binary-to-BCD, commit, scanning.
// Optional signed input mode is enabled by defining DISPLAY_SINAL_EN.
module controle_displays
  import controle_displays_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      numero,
  input  logic             escrever,
  output logic             pronto,
  output logic [BCD_W-1:0] milhar,
  output logic [BCD_W-1:0] centena,
  output logic [BCD_W-1:0] dezena,
  output logic [BCD_W-1:0] unidade,
  output logic             negativo,
  output logic             estouro,
  output logic [3:0]       anodo,
  output logic [BCD_W-1:0] digito_atual
);

  estado_t             estado_q;
  logic [NUM_BITS-1:0] shreg_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sinal_q;
  logic [BCD_W-1:0]    milhar_q, centena_q, dezena_q, unidade_q;
  logic                negativo_q, estouro_q;

  logic [NUM_BITS-1:0] magnitude_d;
  logic                sinal_d;
  logic [ACC_W-1:0]    ajustado;
  logic                unused_alto;

  // Only the low half-word carries the value.
  assign unused_alto = ^numero[31:NUM_BITS];

`ifdef DISPLAY_SINAL_EN
  logic signed [NUM_BITS-1:0] valor_s;
  assign valor_s     = $signed(numero[NUM_BITS-1:0]);
  assign sinal_d     = valor_s[NUM_BITS-1];
  // -32768 negates to itself, which read unsigned is the correct magnitude.
  assign magnitude_d = sinal_d ? $unsigned(-valor_s) : numero[NUM_BITS-1:0];
`else
  assign sinal_d     = 1'b0;
  assign magnitude_d = numero[NUM_BITS-1:0];
`endif

  assign ajustado = soma3(acc_q);
  assign pronto   = (estado_q == OCIOSO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sinal_q    <= 1'b0;
      milhar_q   <= '0;
      centena_q  <= '0;
      dezena_q   <= '0;
      unidade_q  <= '0;
      negativo_q <= 1'b0;
      estouro_q  <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (escrever) begin
            shreg_q  <= magnitude_d;
            sinal_q  <= sinal_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            estado_q <= CONVERTE;
          end
        end
        CONVERTE: begin
          acc_q   <= {ajustado[ACC_W-2:0], shreg_q[NUM_BITS-1]};
          shreg_q <= {shreg_q[NUM_BITS-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_BITS - 1))
            estado_q <= ATUALIZA;
        end
        ATUALIZA: begin
          negativo_q <= sinal_q;
          if (acc_q[ACC_W-1 -: BCD_W] != '0) begin
            estouro_q <= 1'b1;
            milhar_q  <= DIG_ERRO;
            centena_q <= DIG_ERRO;
            dezena_q  <= DIG_ERRO;
            unidade_q <= DIG_ERRO;
          end else begin
            estouro_q <= 1'b0;
            milhar_q  <= acc_q[3*BCD_W +: BCD_W];
            centena_q <= acc_q[2*BCD_W +: BCD_W];
            dezena_q  <= acc_q[1*BCD_W +: BCD_W];
            unidade_q <= acc_q[0*BCD_W +: BCD_W];
          end
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign milhar   = milhar_q;
  assign centena  = centena_q;
  assign dezena   = dezena_q;
  assign unidade  = unidade_q;
  assign negativo = negativo_q;
  assign estouro  = estouro_q;

  varredura_displays #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_varredura (
    .clock_i  (clock),
    .reset_i  (reset),
    .milhar_i (milhar_q),
    .centena_i(centena_q),
    .dezena_i (dezena_q),
    .unidade_i(unidade_q),
    .anodo_o  (anodo),
    .digito_o (digito_atual)
  );

endmodule

// File: tb/tb_controle_displays.sv
// Scoreboard bench for controle_displays: queued expectations checked on each commit.
module tb_controle_displays;

  localparam int RDIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] numero;
  logic        escrever;
  logic        pronto, negativo, estouro;
  logic [3:0]  milhar, centena, dezena, unidade, anodo, digito_atual;

  controle_displays #(.REFRESH_DIV(RDIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .numero      (numero),
    .escrever    (escrever),
    .pronto      (pronto),
    .milhar      (milhar),
    .centena     (centena),
    .dezena      (dezena),
    .unidade     (unidade),
    .negativo    (negativo),
    .estouro     (estouro),
    .anodo       (anodo),
    .digito_atual(digito_atual)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] dig;
    logic        est;
    logic        neg;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [15:0] dig, input logic est, input logic neg);
    exp_t e;
    e.dig = dig;
    e.est = est;
    e.neg = neg;
    return e;
  endfunction

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, act, req, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pronto"}, pronto, 1);
    check({tag, "_digitos"}, {milhar, centena, dezena, unidade}, 16'h0000);
    check({tag, "_estouro"}, estouro, 0);
    check({tag, "_negativo"}, negativo, 0);
    check({tag, "_anodo"}, anodo, 4'b1110);
    check({tag, "_digito_atual"}, digito_atual, 0);
  endtask

  // Monitor: each return of pronto to 1 is a commit to compare against the queue.
  initial begin : monitor
    logic prev;
    int   low;
    exp_t e;
    prev = 1'b1;
    low  = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 1'b1;
        low  = 0;
      end else begin
        if (!pronto) begin
          low++;
        end else if (!prev) begin
          if (exp_q.size() == 0) begin
            check("commit_inesperado", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("digitos", {milhar, centena, dezena, unidade}, e.dig);
            check("estouro", estouro, e.est);
            check("negativo", negativo, e.neg);
            check("pronto_baixo_ciclos", low, 17);
          end
          low = 0;
        end
        prev = pronto;
      end
    end
  end

  // Called at a negedge; the write is accepted at the following posedge.
  task automatic escreve(input logic [31:0] v, input exp_t e);
    int t;
    t = 0;
    while (!pronto && t < 60) begin
      @(negedge clock);
      t++;
    end
    if (!pronto) check("timeout_pronto", 0, 1);
    exp_q.push_back(e);
    numero   = v;
    escrever = 1'b1;
    @(negedge clock);
    escrever = 1'b0;
  endtask

  task automatic espera_fim();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !pronto) && t < 60) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_commit", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  logic [3:0] seq_an [4];
  logic [3:0] seq_dg [4];

  initial begin : estimulo
    int t, idx;
    reset    = 1'b1;
    escrever = 1'b0;
    numero   = '0;
    seq_an[0] = 4'b1110; seq_dg[0] = 4'd4;
    seq_an[1] = 4'b1101; seq_dg[1] = 4'd3;
    seq_an[2] = 4'b1011; seq_dg[2] = 4'd2;
    seq_an[3] = 4'b0111; seq_dg[3] = 4'd1;

    repeat (3) @(negedge clock);
    check_reset("reset_inicial");
    #2 reset = 1'b0;
    @(negedge clock);

    escreve(32'd1234, mk(16'h1234, 1'b0, 1'b0));
    espera_fim();

    // Scanning with 1/2/3/4 committed: sync to an anode change, then step every RDIV cycles.
    t = 0;
    idx = -1;
    begin
      logic [3:0] a0;
      a0 = anodo;
      while (anodo == a0 && t < 20) begin
        @(negedge clock);
        t++;
      end
      check("scan_sincronia", (anodo != a0), 1);
    end
    for (int k = 0; k < 4; k++) if (seq_an[k] == anodo) idx = k;
    check("scan_anodo_valido", (idx >= 0), 1);
    if (idx < 0) idx = 0;
    for (int j = 0; j < 6; j++) begin
      check("scan_anodo", anodo, seq_an[idx]);
      check("scan_digito", digito_atual, seq_dg[idx]);
      repeat (RDIV - 1) @(negedge clock);
      check("scan_estavel", anodo, seq_an[idx]);
      @(negedge clock);
      idx = (idx + 1) % 4;
    end

    escreve(32'd9999, mk(16'h9999, 1'b0, 1'b0));
    espera_fim();
    escreve(32'd10000, mk(16'hFFFF, 1'b1, 1'b0));
    espera_fim();
`ifdef DISPLAY_SINAL_EN
    escreve(32'h0000FFFF, mk(16'h0001, 1'b0, 1'b1));
    espera_fim();
    escreve(32'h00008000, mk(16'hFFFF, 1'b1, 1'b1));
    espera_fim();
`else
    escreve(32'h0000FFFF, mk(16'hFFFF, 1'b1, 1'b0));
    espera_fim();
    escreve(32'h00008000, mk(16'hFFFF, 1'b1, 1'b0));
    espera_fim();
`endif
    // Upper half-word must be ignored.
    escreve(32'hABCD0057, mk(16'h0087, 1'b0, 1'b0));
    espera_fim();

    // Write during conversion must be dropped.
    escreve(32'd42, mk(16'h0042, 1'b0, 1'b0));
    repeat (4) @(negedge clock);
    numero   = 32'd7777;
    escrever = 1'b1;
    @(negedge clock);
    escrever = 1'b0;
    espera_fim();
    repeat (20) @(negedge clock);
    check("ignorado_digitos", {milhar, centena, dezena, unidade}, 16'h0042);

    // Reset in the middle of converting 5555.
    numero   = 32'd5555;
    escrever = 1'b1;
    @(negedge clock);
    escrever = 1'b0;
    repeat (7) @(negedge clock);
    check("pronto_convertendo", pronto, 0);
    #2 reset = 1'b1;
    #1 check_reset("reset_assincrono");
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("pos_reset_pronto", pronto, 1);

    escreve(32'd0, mk(16'h0000, 1'b0, 1'b0));
    espera_fim();

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
